// File: rtl/latch_bank_pkg.sv
// Shared types and slice helpers for the latch_bank storage primitive.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    MODE_DLOAD  = 2'b00,
    MODE_SR     = 2'b01,
    MODE_SRD    = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam int unsigned MODE_W = 32'd2;

  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  function automatic int unsigned mode_lsb(input int unsigned ch);
    return ch * MODE_W;
  endfunction

endpackage

// File: rtl/latch_cell.sv
// One storage channel: per-bit mode decode, q register and sticky change flag.
module latch_cell
  import latch_bank_pkg::*;
#(
  parameter int unsigned            WIDTH     = 32'd8,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  mode_e            mode,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_chg,
  output logic [WIDTH-1:0] q,
  output logic             chg
);

  logic [WIDTH-1:0] q_r;
  logic             chg_r;
  logic [WIDTH-1:0] q_nx_s;
  logic [WIDTH-1:0] load_s;
  logic             changed_s;

  // Next-state decode; bitwise forms give reset > set > load per bit.
  always_comb begin
    q_nx_s = q_r;
    load_s = en ? d : q_r;
    case (mode)
      MODE_DLOAD:  q_nx_s = load_s;
      MODE_SR:     q_nx_s = ~r & (s | q_r);
      MODE_SRD:    q_nx_s = ~r & (s | load_s);
      MODE_TOGGLE: q_nx_s = (s & r & ~q_r) | (s & ~r) | (~s & ~r & q_r);
      default:     q_nx_s = q_r;
    endcase
    changed_s = (q_nx_s != q_r);
  end

  // Storage and sticky flag; a change on the clearing edge keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= RESET_VAL;
      chg_r <= 1'b0;
    end else begin
      q_r   <= q_nx_s;
      chg_r <= changed_s | (chg_r & ~clr_chg);
    end
  end

  assign q   = q_r;
  assign chg = chg_r;

endmodule

// File: rtl/latch_bank.sv
// Bank of independent latch_cell channels with a combined change interrupt.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int unsigned      CHANNELS  = 32'd4,
  parameter int unsigned      WIDTH     = 32'd8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS*WIDTH-1:0] s,
  input  logic [CHANNELS*WIDTH-1:0] r,
  input  logic [CHANNELS-1:0]       clr_chg,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       chg,
  output logic                      irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int unsigned LSB  = chan_lsb(i, WIDTH);
    localparam int unsigned MLSB = mode_lsb(i);

    latch_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode_e'(mode[MLSB +: 2])),
      .en      (en[i]),
      .d       (d[LSB +: WIDTH]),
      .s       (s[LSB +: WIDTH]),
      .r       (r[LSB +: WIDTH]),
      .clr_chg (clr_chg[i]),
      .q       (q[LSB +: WIDTH]),
      .chg     (chg[i])
    );
  end

  // Flags are registered, so the OR cannot glitch.
  assign irq = |chg;

endmodule

// File: tb/tb_latch_bank.sv
// Directed self-checking bench for latch_bank: main 4x8 bank plus 1x1 and 16x32 variants.
module tb_latch_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main bank: 4 channels x 8 bits, RESET_VAL = A5
  logic [7:0]  mode;
  logic [3:0]  en, clr_chg, chg;
  logic [31:0] d, s, r, q;
  logic        irq;

  // 1 x 1 bank
  logic [1:0] p1_mode;
  logic       p1_en, p1_d, p1_s, p1_r, p1_clr, p1_q, p1_chg, p1_irq;

  // 16 x 32 bank
  logic [31:0]  p16_mode;
  logic [15:0]  p16_en, p16_clr, p16_chg;
  logic [511:0] p16_d, p16_s, p16_r, p16_q;
  logic         p16_irq;

  int n_checks = 0;
  int n_fail = 0;

  latch_bank #(.CHANNELS(32'd4), .WIDTH(32'd8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .d(d), .s(s), .r(r),
    .clr_chg(clr_chg), .q(q), .chg(chg), .irq(irq)
  );

  latch_bank #(.CHANNELS(32'd1), .WIDTH(32'd1), .RESET_VAL(1'b1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .mode(p1_mode), .en(p1_en), .d(p1_d), .s(p1_s), .r(p1_r),
    .clr_chg(p1_clr), .q(p1_q), .chg(p1_chg), .irq(p1_irq)
  );

  latch_bank #(.CHANNELS(32'd16), .WIDTH(32'd32), .RESET_VAL(32'h0)) dut_p16 (
    .clk(clk), .rst_n(rst_n), .mode(p16_mode), .en(p16_en), .d(p16_d), .s(p16_s), .r(p16_r),
    .clr_chg(p16_clr), .q(p16_q), .chg(p16_chg), .irq(p16_irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = 8'($urandom); en = 4'($urandom); clr_chg = 4'($urandom);
      d = $urandom; s = $urandom; r = $urandom;
      tick();
    end
    n_checks++; if (q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL reset_q: got %h exp %h", q, 32'hA5A5A5A5); end
    n_checks++; if (chg !== 4'h0) begin n_fail++; $display("FAIL reset_chg: got %h exp %h", chg, 4'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp %b", irq, 1'b0); end
    // first edge after release writes RESET_VAL: no change flagged
    mode = 8'h00; en = 4'hF; d = 32'hA5A5A5A5; s = 32'h0; r = 32'h0; clr_chg = 4'h0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL first_edge_q: got %h exp %h", q, 32'hA5A5A5A5); end
    n_checks++; if (chg !== 4'h0) begin n_fail++; $display("FAIL first_edge_chg: got %h exp %h", chg, 4'h0); end
    en = 4'h0;
  endtask

  task automatic test_dload;
    en = 4'b0001; d = 32'h0000003C;
    tick();
    n_checks++; if (q !== 32'hA5A5A53C) begin n_fail++; $display("FAIL dload_q: got %h exp %h", q, 32'hA5A5A53C); end
    n_checks++; if (chg !== 4'b0001) begin n_fail++; $display("FAIL dload_chg: got %h exp %h", chg, 4'b0001); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL dload_irq: got %b exp %b", irq, 1'b1); end
    en = 4'b0000; d = 32'hFFFFFFFF;
    tick();
    n_checks++; if (q !== 32'hA5A5A53C) begin n_fail++; $display("FAIL dload_hold_q: got %h exp %h", q, 32'hA5A5A53C); end
    n_checks++; if (chg !== 4'b0001) begin n_fail++; $display("FAIL dload_sticky: got %h exp %h", chg, 4'b0001); end
  endtask

  task automatic test_flags;
    clr_chg = 4'b0001;
    tick();
    n_checks++; if (chg !== 4'b0000) begin n_fail++; $display("FAIL clr_chg: got %h exp %h", chg, 4'b0000); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq: got %b exp %b", irq, 1'b0); end
    en = 4'b0001; d = 32'h00000077;
    tick();
    n_checks++; if (q[7:0] !== 8'h77) begin n_fail++; $display("FAIL clr_load_q: got %h exp %h", q[7:0], 8'h77); end
    n_checks++; if (chg !== 4'b0001) begin n_fail++; $display("FAIL set_wins_chg: got %h exp %h", chg, 4'b0001); end
    tick();
    n_checks++; if (chg !== 4'b0000) begin n_fail++; $display("FAIL same_val_clr_chg: got %h exp %h", chg, 4'b0000); end
    clr_chg = 4'b0000;
    tick();
    n_checks++; if (chg !== 4'b0000) begin n_fail++; $display("FAIL same_val_chg: got %h exp %h", chg, 4'b0000); end
    en = 4'b0000;
  endtask

  task automatic test_srd;
    mode = 8'b00_00_10_00;
    r = 32'h0000FF00;
    tick();
    n_checks++; if (q[15:8] !== 8'h00) begin n_fail++; $display("FAIL srd_clear_q: got %h exp %h", q[15:8], 8'h00); end
    r = 32'h00000F00; s = 32'h0000FF00; en = 4'b0010; d = 32'h0000AA00;
    tick();
    n_checks++; if (q[15:8] !== 8'hF0) begin n_fail++; $display("FAIL srd_prio_q: got %h exp %h", q[15:8], 8'hF0); end
    r = 32'h0; s = 32'h0;
    tick();
    n_checks++; if (q[15:8] !== 8'hAA) begin n_fail++; $display("FAIL srd_load_q: got %h exp %h", q[15:8], 8'hAA); end
    // SR mode: en/d ignored, bit7 reset, bit0 set
    mode = 8'b00_00_01_00; d = 32'h0; r = 32'h00008000; s = 32'h00000100;
    tick();
    n_checks++; if (q[15:8] !== 8'h2B) begin n_fail++; $display("FAIL sr_q: got %h exp %h", q[15:8], 8'h2B); end
    n_checks++; if (chg !== 4'b0010) begin n_fail++; $display("FAIL sr_chg: got %h exp %h", chg, 4'b0010); end
    r = 32'h0; s = 32'h0; en = 4'b0000;
  endtask

  task automatic test_toggle;
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hAA; exp_seq[1] = 8'h55; exp_seq[2] = 8'hAA;
    mode = 8'b00_00_01_00; en = 4'b0100; d = 32'h00550000;
    tick();
    n_checks++; if (q[23:16] !== 8'h55) begin n_fail++; $display("FAIL tog_preload: got %h exp %h", q[23:16], 8'h55); end
    mode = 8'b00_11_01_00; en = 4'b0000; s = 32'h00FF0000; r = 32'h00FF0000; clr_chg = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (q[23:16] !== exp_seq[i]) begin n_fail++; $display("FAIL tog_q[%0d]: got %h exp %h", i, q[23:16], exp_seq[i]); end
      n_checks++; if (chg[2] !== 1'b1) begin n_fail++; $display("FAIL tog_chg[%0d]: got %b exp %b", i, chg[2], 1'b1); end
    end
    s = 32'h0; r = 32'h000F0000;
    tick();
    n_checks++; if (q[23:16] !== 8'hA0) begin n_fail++; $display("FAIL tog_r_only: got %h exp %h", q[23:16], 8'hA0); end
    s = 32'h00010000; r = 32'h0;
    tick();
    n_checks++; if (q[23:16] !== 8'hA1) begin n_fail++; $display("FAIL tog_s_only: got %h exp %h", q[23:16], 8'hA1); end
    s = 32'h0;
    tick();
    n_checks++; if (q[23:16] !== 8'hA1) begin n_fail++; $display("FAIL tog_hold: got %h exp %h", q[23:16], 8'hA1); end
    n_checks++; if (chg[2] !== 1'b0) begin n_fail++; $display("FAIL tog_hold_chg: got %b exp %b", chg[2], 1'b0); end
    clr_chg = 4'b0000;
  endtask

  task automatic test_all_channels;
    mode = 8'h00; en = 4'h0; clr_chg = 4'hF;
    tick();
    n_checks++; if (chg !== 4'h0) begin n_fail++; $display("FAIL all_clr: got %h exp %h", chg, 4'h0); end
    clr_chg = 4'h0; en = 4'hF; d = 32'h11223344;
    tick();
    n_checks++; if (q !== 32'h11223344) begin n_fail++; $display("FAIL all_q: got %h exp %h", q, 32'h11223344); end
    n_checks++; if (chg !== 4'hF) begin n_fail++; $display("FAIL all_chg: got %h exp %h", chg, 4'hF); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL all_irq: got %b exp %b", irq, 1'b1); end
  endtask

  task automatic test_async_reset;
    en = 4'hF; d = 32'h5A5A5A5A;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL async_q: got %h exp %h", q, 32'hA5A5A5A5); end
    n_checks++; if (chg !== 4'h0) begin n_fail++; $display("FAIL async_chg: got %h exp %h", chg, 4'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq: got %b exp %b", irq, 1'b0); end
    en = 4'h0;
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (q !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL async_after_q: got %h exp %h", q, 32'hA5A5A5A5); end
  endtask

  task automatic test_param;
    n_checks++; if (p1_q !== 1'b1) begin n_fail++; $display("FAIL p1_reset_q: got %b exp %b", p1_q, 1'b1); end
    p1_mode = 2'b00; p1_en = 1'b1; p1_d = 1'b0;
    p16_mode = 32'h0; p16_en = 16'h8000; p16_d = 512'h0; p16_d[511:480] = 32'hDEADBEEF;
    tick();
    n_checks++; if (p1_q !== 1'b0) begin n_fail++; $display("FAIL p1_dload_q: got %b exp %b", p1_q, 1'b0); end
    n_checks++; if (p1_irq !== 1'b1) begin n_fail++; $display("FAIL p1_irq: got %b exp %b", p1_irq, 1'b1); end
    n_checks++; if (p16_q[511:480] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL p16_ch15_q: got %h exp %h", p16_q[511:480], 32'hDEADBEEF); end
    n_checks++; if (p16_q[479:0] !== 480'h0) begin n_fail++; $display("FAIL p16_low_q: got %h exp 0", p16_q[479:0]); end
    n_checks++; if (p16_chg !== 16'h8000) begin n_fail++; $display("FAIL p16_chg: got %h exp %h", p16_chg, 16'h8000); end
    p1_mode = 2'b10; p1_s = 1'b1; p1_r = 1'b0; p1_d = 1'b0;
    p16_mode = 32'h8000_0003; p16_en = 16'h8000; p16_d[511:480] = 32'h12345678;
    p16_s[511:480] = 32'hFFFFFFFF; p16_r[511:480] = 32'h0000FFFF;
    p16_s[31:0] = 32'hFFFFFFFF; p16_r[31:0] = 32'hFFFFFFFF;
    tick();
    n_checks++; if (p1_q !== 1'b1) begin n_fail++; $display("FAIL p1_srd_q: got %b exp %b", p1_q, 1'b1); end
    n_checks++; if (p16_q[511:480] !== 32'hFFFF0000) begin n_fail++; $display("FAIL p16_srd_q: got %h exp %h", p16_q[511:480], 32'hFFFF0000); end
    n_checks++; if (p16_q[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL p16_tog_q: got %h exp %h", p16_q[31:0], 32'hFFFFFFFF); end
    n_checks++; if (p16_chg !== 16'h8001) begin n_fail++; $display("FAIL p16_chg2: got %h exp %h", p16_chg, 16'h8001); end
    p1_mode = 2'b11; p1_s = 1'b1; p1_r = 1'b1; p1_en = 1'b0; p1_clr = 1'b1;
    tick();
    n_checks++; if (p1_q !== 1'b0) begin n_fail++; $display("FAIL p1_tog0_q: got %b exp %b", p1_q, 1'b0); end
    tick();
    n_checks++; if (p1_q !== 1'b1) begin n_fail++; $display("FAIL p1_tog1_q: got %b exp %b", p1_q, 1'b1); end
    n_checks++; if (p1_chg !== 1'b1) begin n_fail++; $display("FAIL p1_tog_chg: got %b exp %b", p1_chg, 1'b1); end
  endtask

  initial begin
    mode = 8'h0; en = 4'h0; clr_chg = 4'h0; d = 32'h0; s = 32'h0; r = 32'h0;
    p1_mode = 2'b00; p1_en = 1'b0; p1_d = 1'b0; p1_s = 1'b0; p1_r = 1'b0; p1_clr = 1'b0;
    p16_mode = 32'h0; p16_en = 16'h0; p16_clr = 16'h0; p16_d = 512'h0; p16_s = 512'h0; p16_r = 512'h0;
    test_reset();
    test_dload();
    test_flags();
    test_srd();
    test_toggle();
    test_all_channels();
    test_async_reset();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
